icache_mem_ctrl: RTL and testbench
==================================

# icache_mem_ctrl

Miss-service controller between the instruction cache, the data cache and the single shared main-memory port. It accepts level-held line-miss requests from the I-cache (Fetch) and the D-cache and arbitrates between them. For the D-cache it sequences an optional dirty-line writeback before the refill read. It returns the fetched 128-bit line to the requesting cache as a one-cycle fill-write pulse (WiCache/WiCacheline/WiCachetag on the Fetch side). It sits outside the pipeline; the stages stall on their own miss signals until the fill lands.

## Interface
- TAG_W, 9: line address (tag) width on all cache and memory ports
- LINE_W, 128: cache line width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- ICacheMiss  in  1  I-cache line miss, held high until filled
- ICacheMiss_tag  in  TAG_W  missing I-line address, stable while ICacheMiss
- DCacheMiss  in  1  D-cache line miss, held high until filled
- DCacheMiss_tag  in  TAG_W  missing D-line address
- DCacheDirty  in  1  victim line dirty, valid with DCacheMiss
- DCacheVictim_tag  in  TAG_W  victim line address
- DCacheVictim_line  in  LINE_W  victim line data
- WiCache  out  1  I-cache fill strobe, one cycle
- WiCacheline  out  LINE_W  I-cache fill data
- WiCachetag  out  TAG_W  I-cache fill address
- WdCache  out  1  D-cache fill strobe, one cycle
- WdCacheline  out  LINE_W  D-cache fill data
- WdCachetag  out  TAG_W  D-cache fill address
- mem_req  out  1  memory request, held until mem_valid
- mem_we  out  1  1 = line write, 0 = line read
- mem_addr  out  TAG_W  line address
- mem_wdata  out  LINE_W  write data
- mem_valid  in  1  read data valid / write accepted, one cycle
- mem_rdata  in  LINE_W  read line
- busy  out  1  state != IDLE

## Operation
- States: IDLE, I_RD, D_WB, D_RD, I_FILL, D_FILL.
- IDLE:
  - Only ICacheMiss → I_RD.
  - Only DCacheMiss → D_WB if DCacheDirty, else D_RD.
  - Both → arbitration (see Configuration).
  - Request address and victim tag/line are latched on the grant edge.
- I_RD / D_RD: mem_req=1, mem_we=0, mem_addr=latched tag. On mem_valid, capture mem_rdata → I_FILL / D_FILL.
- D_WB: mem_req=1, mem_we=1, mem_addr=victim tag, mem_wdata=victim line. On mem_valid → D_RD.
- I_FILL: WiCache=1, WiCacheline=captured line, WiCachetag=latched tag → IDLE.
- D_FILL: same on the Wd* outputs → IDLE.
- Cache-side outputs and mem_wdata/mem_addr are registered; strobes are decoded from the state register only.
- A miss that drops before service completes is ignored. The transaction finishes and the fill is still issued; the cache must accept it.
- Reset (any state, including mid-transaction):
  - State → IDLE; every output 0; latched tags/lines cleared; last-grant → I-cache.
  - The outstanding memory transaction is abandoned; memory must also reset.

## Timing
- Miss sampled high at edge k: I_RD from cycle k+1 (mem_req high).
- mem_valid sampled at edge m: fill strobe high in cycle m+1 only. I-side minimum miss-to-WiCache is 2 cycles.
- Fill write and return to IDLE happen on the same edge. The cache's miss is re-evaluated in the first IDLE cycle, with no dead cycle.
- Dirty D miss: writeback and read are back-to-back (D_RD starts the cycle after write mem_valid).
- mem_valid outside I_RD/D_RD/D_WB is ignored.

## Configuration
- ICMEMCTRL_RR_EN defined: round-robin on simultaneous misses. The requester not granted last wins; last-grant updates on every grant.
- Undefined: fixed priority, D-cache always wins; last-grant register is not built.

## Structure
- Package icache_mem_ctrl_pkg:
  - state enum and encoding
  - TAG_W/LINE_W defaults
  - requester ID constants (REQ_I, REQ_D)
- Sub-module arb_rr2: two-requester arbiter (req[1:0] → one-hot grant, last-grant flop). It holds both the RR and fixed-priority variants under ICMEMCTRL_RR_EN.

## Test plan
- I miss only, tag 9'h05A, memory answers 3 cycles after mem_req with 128'hDEADBEEF…: mem_addr=05A, mem_we=0; WiCache high exactly 1 cycle with that line and tag 05A; busy low the next cycle.
- Clean D miss, tag 9'h1F0: single read only, WdCache pulse with read data; no mem_we=1 cycle.
- Dirty D miss, victim tag 9'h0AA, line 128'h1234…: write to 0AA with victim data first, then read of the miss tag; WdCache after the second mem_valid.
- Simultaneous I and D misses held across three transactions:
  - RR_EN: grants alternate D, I, D after a reset to I-last.
  - No RR_EN: D always granted first.
- Reset asserted mid D_WB: all outputs 0 asynchronously. After release with no misses: IDLE, mem_req=0, no fill strobe ever issued.
- mem_valid spuriously high in IDLE: no state change, no strobe.

Source files
------------

// File: rtl/icache_mem_ctrl_pkg.sv
// Shared types and constants for the I/D-cache miss-service controller.
package icache_mem_ctrl_pkg;

  localparam int TAG_W  = 9;
  localparam int LINE_W = 128;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_RD   = 3'd1,
    D_WB   = 3'd2,
    D_RD   = 3'd3,
    I_FILL = 3'd4,
    D_FILL = 3'd5
  } state_e;

endpackage

// File: rtl/icache_mem_ctrl_if.sv
// Cache-miss, fill and memory-port bundle of the miss-service controller.
interface icache_mem_ctrl_if
  import icache_mem_ctrl_pkg::*;
();

  logic  ICacheMiss;
  tag_t  ICacheMiss_tag;
  logic  DCacheMiss;
  tag_t  DCacheMiss_tag;
  logic  DCacheDirty;
  tag_t  DCacheVictim_tag;
  line_t DCacheVictim_line;

  logic  WiCache;
  line_t WiCacheline;
  tag_t  WiCachetag;
  logic  WdCache;
  line_t WdCacheline;
  tag_t  WdCachetag;

  logic  mem_req;
  logic  mem_we;
  tag_t  mem_addr;
  line_t mem_wdata;
  logic  mem_valid;
  line_t mem_rdata;

  logic  busy;

  modport master (
    input  ICacheMiss, ICacheMiss_tag,
    input  DCacheMiss, DCacheMiss_tag, DCacheDirty,
    input  DCacheVictim_tag, DCacheVictim_line,
    output WiCache, WiCacheline, WiCachetag,
    output WdCache, WdCacheline, WdCachetag,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_valid, mem_rdata,
    output busy
  );

  modport slave (
    output ICacheMiss, ICacheMiss_tag,
    output DCacheMiss, DCacheMiss_tag, DCacheDirty,
    output DCacheVictim_tag, DCacheVictim_line,
    input  WiCache, WiCacheline, WiCachetag,
    input  WdCache, WdCacheline, WdCachetag,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_valid, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/icache_mem_ctrl_arb_rr2.sv
// Two-requester arbiter: round-robin with ICMEMCTRL_RR_EN, else D-cache
// fixed priority (no last-grant flop).
module arb_rr2
  import icache_mem_ctrl_pkg::*;
(
`ifdef ICMEMCTRL_RR_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
`endif
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef ICMEMCTRL_RR_EN
  // last_q: 1 = D-cache granted last
  logic last_q, last_d;

  assign last_d = en_i ? gnt_o[REQ_D] : last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= last_d;
  end

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o[REQ_I] = last_q;
      gnt_o[REQ_D] = ~last_q;
    end
  end
`else
  always_comb begin
    gnt_o = req_i;
    if (req_i[REQ_D]) gnt_o[REQ_I] = 1'b0;
  end
`endif

endmodule

// File: rtl/icache_mem_ctrl.sv
// Miss-service controller sharing one memory port between I- and D-cache.
// Round-robin arbitration on simultaneous misses with ICMEMCTRL_RR_EN.
module icache_mem_ctrl
  import icache_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  icache_mem_ctrl_if.master bus
);

  state_e     state_q, state_d;
  tag_t       tag_q, tag_d;
  tag_t       addr_q, addr_d;
  line_t      line_q, line_d;
  line_t      wdata_q, wdata_d;
  logic [1:0] req, gnt;

  assign req[REQ_I] = bus.ICacheMiss;
  assign req[REQ_D] = bus.DCacheMiss;

`ifdef ICMEMCTRL_RR_EN
  logic grant_en;
  assign grant_en = (state_q == IDLE) && (|req);

  arb_rr2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (grant_en),
    .req_i (req),
    .gnt_o (gnt)
  );
`else
  arb_rr2 u_arb (
    .req_i (req),
    .gnt_o (gnt)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    line_d  = line_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt[REQ_D]) begin
          tag_d = bus.DCacheMiss_tag;
          if (bus.DCacheDirty) begin
            state_d = D_WB;
            addr_d  = bus.DCacheVictim_tag;
            wdata_d = bus.DCacheVictim_line;
          end else begin
            state_d = D_RD;
            addr_d  = bus.DCacheMiss_tag;
          end
        end else if (gnt[REQ_I]) begin
          state_d = I_RD;
          tag_d   = bus.ICacheMiss_tag;
          addr_d  = bus.ICacheMiss_tag;
        end
      end
      I_RD: begin
        if (bus.mem_valid) begin
          line_d  = bus.mem_rdata;
          state_d = I_FILL;
        end
      end
      D_WB: begin
        // writeback accepted: refill read follows back-to-back
        if (bus.mem_valid) begin
          addr_d  = tag_q;
          state_d = D_RD;
        end
      end
      D_RD: begin
        if (bus.mem_valid) begin
          line_d  = bus.mem_rdata;
          state_d = D_FILL;
        end
      end
      I_FILL,
      D_FILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req = (state_q == I_RD) ||
                       (state_q == D_RD) ||
                       (state_q == D_WB);
  assign bus.mem_we    = (state_q == D_WB);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.WiCache     = (state_q == I_FILL);
  assign bus.WiCacheline = line_q;
  assign bus.WiCachetag  = tag_q;
  assign bus.WdCache     = (state_q == D_FILL);
  assign bus.WdCacheline = line_q;
  assign bus.WdCachetag  = tag_q;

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_icache_mem_ctrl.sv
// Randomized bench for icache_mem_ctrl against a transaction-level model.
module tb_icache_mem_ctrl;
  import icache_mem_ctrl_pkg::*;

`ifdef ICMEMCTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic  we;
    tag_t  addr;
    line_t data;
  } op_t;

  typedef struct {
    logic  side;
    tag_t  tag;
    line_t line;
  } fill_t;

  typedef struct {
    tag_t  tag;
    logic  dirty;
    tag_t  vtag;
    line_t vline;
  } dreq_t;

  logic clk = 1'b0;
  logic reset;

  icache_mem_ctrl_if bus();

  icache_mem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  line_t   mem_arr [0:(1<<TAG_W)-1];
  line_t   ref_mem [0:(1<<TAG_W)-1];
  tag_t    iq[$];
  dreq_t   dq[$];
  op_t     exp_ops[$];
  op_t     got_ops[$];
  fill_t   exp_fills[$];
  fill_t   got_fills[$];
  logic    model_last_d;
  int      lat, cnt, cyc, last_rd_fire;
  logic    prev_fill, prev_wr_fire;

  task automatic chk(input string tag, input line_t obs, input line_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.WiCache, bus.WiCacheline, bus.WiCachetag,
             bus.WdCache, bus.WdCacheline, bus.WdCachetag,
             bus.mem_req, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, bus.busy};
  endfunction

  function automatic line_t rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic present_i();
    if (iq.size() > 0) begin
      bus.ICacheMiss     = 1'b1;
      bus.ICacheMiss_tag = iq[0];
    end else begin
      bus.ICacheMiss     = 1'b0;
    end
  endtask

  task automatic present_d();
    if (dq.size() > 0) begin
      bus.DCacheMiss        = 1'b1;
      bus.DCacheMiss_tag    = dq[0].tag;
      bus.DCacheDirty       = dq[0].dirty;
      bus.DCacheVictim_tag  = dq[0].vtag;
      bus.DCacheVictim_line = dq[0].vline;
    end else begin
      bus.DCacheMiss  = 1'b0;
      bus.DCacheDirty = 1'b0;
    end
  endtask

  // One cycle: sample at negedge, act as memory and both caches.
  task automatic step();
    fill_t f;
    op_t   o;
    @(negedge clk);
    cyc++;
    if (prev_fill)
      chk("idle_after_fill", line_t'({bus.busy, bus.WiCache, bus.WdCache}), '0);
    if (prev_wr_fire)
      chk("wb_then_rd", line_t'({bus.mem_req, bus.mem_we}), line_t'(2'b10));
    prev_fill    = 1'b0;
    prev_wr_fire = 1'b0;
    if (bus.WiCache || bus.WdCache) begin
      chk("fill_one_side", line_t'(bus.WiCache & bus.WdCache), '0);
      chk("fill_latency", line_t'(cyc - last_rd_fire), line_t'(1));
      f.side = bus.WdCache;
      f.tag  = bus.WdCache ? bus.WdCachetag  : bus.WiCachetag;
      f.line = bus.WdCache ? bus.WdCacheline : bus.WiCacheline;
      got_fills.push_back(f);
      prev_fill = 1'b1;
      if (bus.WdCache) begin
        if (dq.size() > 0) void'(dq.pop_front());
        present_d();
      end else begin
        if (iq.size() > 0) void'(iq.pop_front());
        present_i();
      end
    end
    bus.mem_valid = 1'b0;
    if (bus.mem_req) begin
      cnt++;
      if (cnt >= lat) begin
        o.we   = bus.mem_we;
        o.addr = bus.mem_addr;
        o.data = bus.mem_we ? bus.mem_wdata : '0;
        got_ops.push_back(o);
        if (bus.mem_we) begin
          mem_arr[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = rnd_line();
          prev_wr_fire = 1'b1;
        end else begin
          bus.mem_rdata = mem_arr[bus.mem_addr];
          last_rd_fire = cyc;
        end
        bus.mem_valid = 1'b1;
        cnt = 0;
        lat = $urandom_range(1, 4);
      end
    end else begin
      cnt = 0;
    end
  endtask

  // Transaction-level model: grant order, memory traffic and fills.
  task automatic build_model();
    tag_t  mi[$];
    dreq_t md[$];
    dreq_t r;
    tag_t  t;
    logic  gd;
    op_t   o;
    fill_t f;
    mi = iq;
    md = dq;
    exp_ops.delete();
    exp_fills.delete();
    for (int a = 0; a < (1<<TAG_W); a++) ref_mem[a] = mem_arr[a];
    while (mi.size() > 0 || md.size() > 0) begin
      if (mi.size() > 0 && md.size() > 0) gd = RR ? ~model_last_d : 1'b1;
      else                                gd = (md.size() > 0);
      model_last_d = gd;
      if (gd) begin
        r = md.pop_front();
        if (r.dirty) begin
          o.we = 1'b1; o.addr = r.vtag; o.data = r.vline;
          exp_ops.push_back(o);
          ref_mem[r.vtag] = r.vline;
        end
        o.we = 1'b0; o.addr = r.tag; o.data = '0;
        exp_ops.push_back(o);
        f.side = 1'b1; f.tag = r.tag; f.line = ref_mem[r.tag];
        exp_fills.push_back(f);
      end else begin
        t = mi.pop_front();
        o.we = 1'b0; o.addr = t; o.data = '0;
        exp_ops.push_back(o);
        f.side = 1'b0; f.tag = t; f.line = ref_mem[t];
        exp_fills.push_back(f);
      end
    end
  endtask

  task automatic run_episode(input string name, input int lat0);
    int budget;
    build_model();
    got_ops.delete();
    got_fills.delete();
    lat = lat0;
    cnt = 0;
    @(negedge clk);
    present_i();
    present_d();
    step();
    chk({name, "_req_next"}, line_t'(bus.mem_req), line_t'(1));
    budget = 300;
    while ((iq.size() > 0 || dq.size() > 0 || bus.busy) && budget > 0) begin
      step();
      budget--;
    end
    chk({name, "_done"}, line_t'(budget > 0), line_t'(1));
    chk({name, "_nops"}, line_t'(got_ops.size()), line_t'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++) begin
      chk($sformatf("%s_op%0d_we", name, i),
          line_t'(got_ops[i].we), line_t'(exp_ops[i].we));
      chk($sformatf("%s_op%0d_addr", name, i),
          line_t'(got_ops[i].addr), line_t'(exp_ops[i].addr));
      chk($sformatf("%s_op%0d_wdata", name, i), got_ops[i].data, exp_ops[i].data);
    end
    chk({name, "_nfills"}, line_t'(got_fills.size()), line_t'(exp_fills.size()));
    for (int i = 0; i < exp_fills.size() && i < got_fills.size(); i++) begin
      chk($sformatf("%s_fill%0d_side", name, i),
          line_t'(got_fills[i].side), line_t'(exp_fills[i].side));
      chk($sformatf("%s_fill%0d_tag", name, i),
          line_t'(got_fills[i].tag), line_t'(exp_fills[i].tag));
      chk($sformatf("%s_fill%0d_line", name, i), got_fills[i].line, exp_fills[i].line);
    end
  endtask

  initial begin
    dreq_t r;
    int    ni, nd;
    reset                 = 1'b1;
    bus.ICacheMiss        = 1'b0;
    bus.ICacheMiss_tag    = '0;
    bus.DCacheMiss        = 1'b0;
    bus.DCacheMiss_tag    = '0;
    bus.DCacheDirty       = 1'b0;
    bus.DCacheVictim_tag  = '0;
    bus.DCacheVictim_line = '0;
    bus.mem_valid         = 1'b0;
    bus.mem_rdata         = '0;
    for (int a = 0; a < (1<<TAG_W); a++) mem_arr[a] = rnd_line();
    model_last_d = 1'b0;
    cnt = 0; lat = 1; cyc = 0; last_rd_fire = -10;
    prev_fill = 1'b0; prev_wr_fire = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", line_t'(any_out()), '0);
    reset = 1'b0;
    @(negedge clk);

    mem_arr[9'h05A] = 128'hDEADBEEF_CAFEF00D_DEADBEEF_CAFEF00D;
    iq.push_back(9'h05A);
    run_episode("i_only", 3);

    r.tag = 9'h1F0; r.dirty = 1'b0; r.vtag = 9'h011; r.vline = rnd_line();
    dq.push_back(r);
    run_episode("d_clean", 2);

    r.tag = 9'h133; r.dirty = 1'b1; r.vtag = 9'h0AA;
    r.vline = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    dq.push_back(r);
    run_episode("d_dirty", 3);

    // simultaneous misses from a fresh reset, D re-misses once
    @(negedge clk);
    reset = 1'b1;
    model_last_d = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    iq.push_back(9'h044);
    r.tag = 9'h101; r.dirty = 1'b0; r.vtag = 9'h000; r.vline = rnd_line();
    dq.push_back(r);
    r.tag = 9'h102; r.dirty = 1'b1; r.vtag = 9'h0F3; r.vline = rnd_line();
    dq.push_back(r);
    run_episode("both_held", 2);

    // reset in the middle of a writeback
    r.tag = 9'h155; r.dirty = 1'b1; r.vtag = 9'h0AB; r.vline = rnd_line();
    dq.push_back(r);
    lat = 12;
    cnt = 0;
    @(negedge clk);
    present_d();
    for (int i = 0; i < 6 && !bus.mem_we; i++) step();
    chk("reached_wb", line_t'(bus.mem_we), line_t'(1));
    #2 reset = 1'b1;
    #1 chk("rst_async_zero", line_t'(any_out()), '0);
    iq.delete();
    dq.delete();
    present_i();
    present_d();
    bus.mem_valid = 1'b0;
    cnt = 0;
    model_last_d = 1'b0;
    prev_fill = 1'b0;
    prev_wr_fire = 1'b0;
    got_fills.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      step();
      chk("post_rst_idle", line_t'({bus.mem_req, bus.busy}), '0);
    end
    chk("post_rst_no_fill", line_t'(got_fills.size()), '0);

    // spurious mem_valid while idle
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_rdata = rnd_line();
    @(negedge clk);
    bus.mem_valid = 1'b0;
    chk("spurious_idle",
        line_t'({bus.busy, bus.mem_req, bus.WiCache, bus.WdCache}), '0);
    @(negedge clk);
    chk("spurious_no_strobe",
        line_t'({bus.busy, bus.mem_req, bus.WiCache, bus.WdCache}), '0);

    for (int e = 0; e < 24; e++) begin
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 2);
      if (ni + nd == 0) ni = 1;
      for (int k = 0; k < ni; k++) iq.push_back(tag_t'($urandom()));
      for (int k = 0; k < nd; k++) begin
        r.tag   = tag_t'($urandom());
        r.dirty = 1'($urandom_range(0, 1));
        r.vtag  = tag_t'($urandom());
        r.vline = rnd_line();
        dq.push_back(r);
      end
      run_episode($sformatf("rnd%0d", e), $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
